// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants and nibble helpers for the BCD up-counter.
//   DIGIT_W      - bits per BCD digit
//   BCD_MAX      - largest legal BCD digit value
//   bcd_sanitize - maps an illegal nibble (>9) to 0 (used on load values)
//   bcd_clamp    - maps an illegal nibble (>9) to 9 (used on the terminal value)
package bcd_pkg;

    localparam int         DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic [3:0] bcd_sanitize(input logic [3:0] nibble);
        return (nibble > BCD_MAX) ? 4'd0 : nibble;
    endfunction

    function automatic logic [3:0] bcd_clamp(input logic [3:0] nibble);
        return (nibble > BCD_MAX) ? BCD_MAX : nibble;
    endfunction

endpackage

// File: rtl/bcd_up_counter_if.sv
// bcd_up_counter_if: control/data bundle between a counter user and the
// BCD up-counter.
//   en       - count enable (gates prescaler and counter)
//   clr      - synchronous clear
//   load     - synchronous load strobe
//   load_val - BCD value to load, digit 0 in bits [3:0]
//   limit    - terminal BCD value
//   cnt      - registered BCD count
//   carry    - registered terminal indication
// Modports: master drives the controls, slave is the counter.
interface bcd_up_counter_if #(
    parameter int DIGITS = 2
);
    logic                  en;
    logic                  clr;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   limit;
    logic [4*DIGITS-1:0]   cnt;
    logic                  carry;

    modport master (
        output en, clr, load, load_val, limit,
        input  cnt, carry
    );

    modport slave (
        input  en, clr, load, load_val, limit,
        output cnt, carry
    );
endinterface

// File: rtl/bcd_up_counter_digit.sv
// bcd_digit: one combinational BCD digit cell of the increment chain.
//   digit_i - current digit value (always a legal BCD digit in use)
//   inc_i   - increment request from the lower digit
//   digit_o - digit value after the optional increment (9 rolls to 0)
//   inc_o   - increment request for the next higher digit
module bcd_digit
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    input  logic               inc_i,
    output logic [DIGIT_W-1:0] digit_o,
    output logic               inc_o
);

    // >= rather than == so an illegal digit can never produce an illegal result
    assign digit_o = !inc_i              ? digit_i :
                     (digit_i >= BCD_MAX) ? '0      :
                                            digit_i + 4'd1;
    assign inc_o   = inc_i && (digit_i == BCD_MAX);

endmodule

// File: rtl/bcd_up_counter.sv
// bcd_up_counter: multi-digit synchronous BCD up-counter with prescaler,
// synchronous clear, load and a programmable terminal value.
//   clk - rising-edge clock
//   rst - asynchronous active-low reset
//   bus - bcd_up_counter_if.slave (en, clr, load, load_val, limit, cnt, carry)
// Parameters: DIGITS (BCD digits), DIV (advance once per DIV enabled clocks).
// Build option: define BCD_UP_SAT_EN for the saturating build (cnt holds at
// the terminal value and carry is a level); otherwise the counter wraps to 0
// and carry is a one-cycle pulse.
module bcd_up_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int DIV    = 1
) (
    input  logic             clk,
    input  logic             rst,
    bcd_up_counter_if.slave  bus
);

    localparam int             VW       = DIGIT_W * DIGITS;
    localparam int             PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  PSC_LAST = PW'(DIV - 1);

    logic [PW-1:0] psc_q, psc_d;
    logic [VW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d;

    logic [VW-1:0] lim_c;
    logic [VW-1:0] load_c;
    logic [VW-1:0] inc_val;
    logic [DIGITS:0] inc_chain;
    logic          at_limit;
    logic          terminal;

    always_comb begin
        lim_c  = '0;
        load_c = '0;
        for (int i = 0; i < DIGITS; i++) begin
            lim_c[i*DIGIT_W +: DIGIT_W]  = bcd_clamp(bus.limit[i*DIGIT_W +: DIGIT_W]);
            load_c[i*DIGIT_W +: DIGIT_W] = bcd_sanitize(bus.load_val[i*DIGIT_W +: DIGIT_W]);
        end
    end

    // Ripple increment chain: digit 0 always requests +1, each cell passes
    // its roll-over into the next within the same cycle.
    assign inc_chain[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .digit_i (cnt_q[g*DIGIT_W +: DIGIT_W]),
            .inc_i   (inc_chain[g]),
            .digit_o (inc_val[g*DIGIT_W +: DIGIT_W]),
            .inc_o   (inc_chain[g+1])
        );
    end

    // Terminal when the count equals the limit, or when it sits at all-nines
    // (only reachable above the limit, via load or a lowered limit).
    assign at_limit = (cnt_q == lim_c);
    assign terminal = at_limit || inc_chain[DIGITS];

    always_comb begin
        cnt_d = cnt_q;
        psc_d = psc_q;
`ifdef BCD_UP_SAT_EN
        carry_d = carry_q;
`else
        carry_d = 1'b0;
`endif
        if (bus.clr) begin
            cnt_d   = '0;
            psc_d   = '0;
            carry_d = 1'b0;
        end else if (bus.load) begin
            cnt_d   = load_c;
            psc_d   = '0;
            carry_d = 1'b0;
        end else if (bus.en) begin
            if (psc_q == PSC_LAST) begin
                psc_d = '0;
`ifdef BCD_UP_SAT_EN
                // Once saturated, further advances are ignored.
                if (!carry_q) begin
                    if (terminal) begin
                        carry_d = 1'b1;
                    end else begin
                        cnt_d = inc_val;
                    end
                end
`else
                if (terminal) begin
                    cnt_d   = '0;
                    carry_d = 1'b1;
                end else begin
                    cnt_d = inc_val;
                end
`endif
            end else begin
                psc_d = psc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            psc_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            psc_q   <= psc_d;
            carry_q <= carry_d;
        end
    end

    assign bus.cnt   = cnt_q;
    assign bus.carry = carry_q;

endmodule

// File: tb/tb_bcd_up_counter.sv
// tb_bcd_up_counter: self-checking bench for bcd_up_counter. Two instances
// (DIV=1 and DIV=4, DIGITS=2) share one stimulus stream; a decimal integer
// reference model predicts each instance's count and carry every cycle.
// Honours BCD_UP_SAT_EN to select the saturating reference behaviour.
module tb_bcd_up_counter;

    logic clk;
    logic rst;
    logic en, clr, load;
    logic [7:0] load_val, limit;

    int n_cmp;
    int n_err;

    int m_cnt [2];
    int m_psc [2];
    bit m_car [2];
    int m_div [2];

    bcd_up_counter_if #(.DIGITS(2)) bus1 ();
    bcd_up_counter_if #(.DIGITS(2)) bus4 ();

    assign bus1.en = en;       assign bus4.en = en;
    assign bus1.clr = clr;     assign bus4.clr = clr;
    assign bus1.load = load;   assign bus4.load = load;
    assign bus1.load_val = load_val; assign bus4.load_val = load_val;
    assign bus1.limit = limit; assign bus4.limit = limit;

    bcd_up_counter #(.DIGITS(2), .DIV(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    bcd_up_counter #(.DIGITS(2), .DIV(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Decimal value of a BCD byte; illegal nibbles become 9 (clamp) or 0.
    function automatic int bcd_to_int(input logic [7:0] v, input bit clamp);
        int d0, d1;
        d0 = int'(v[3:0]);
        d1 = int'(v[7:4]);
        if (d0 > 9) d0 = clamp ? 9 : 0;
        if (d1 > 9) d1 = clamp ? 9 : 0;
        return d1 * 10 + d0;
    endfunction

    function automatic logic [7:0] int_to_bcd(input int n);
        logic [7:0] r;
        r[7:4] = 4'(n / 10);
        r[3:0] = 4'(n % 10);
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0;
            m_psc[k] = 0;
            m_car[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        int lim;
        lim = bcd_to_int(limit, 1'b1);
        for (int k = 0; k < 2; k++) begin
            if (clr) begin
                m_cnt[k] = 0; m_psc[k] = 0; m_car[k] = 1'b0;
            end else if (load) begin
                m_cnt[k] = bcd_to_int(load_val, 1'b0); m_psc[k] = 0; m_car[k] = 1'b0;
            end else if (en && m_psc[k] == m_div[k] - 1) begin
                m_psc[k] = 0;
`ifdef BCD_UP_SAT_EN
                if (!m_car[k]) begin
                    if (m_cnt[k] == lim || m_cnt[k] == 99) m_car[k] = 1'b1;
                    else m_cnt[k] = m_cnt[k] + 1;
                end
`else
                if (m_cnt[k] == lim || m_cnt[k] == 99) begin
                    m_cnt[k] = 0; m_car[k] = 1'b1;
                end else begin
                    m_cnt[k] = m_cnt[k] + 1; m_car[k] = 1'b0;
                end
`endif
            end else begin
                if (en) m_psc[k] = m_psc[k] + 1;
`ifndef BCD_UP_SAT_EN
                m_car[k] = 1'b0;
`endif
            end
        end
    endtask

    // One clock: model follows the edge, outputs are checked 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("cnt_div1",   32'(bus1.cnt),   32'(int_to_bcd(m_cnt[0])));
        chk("carry_div1", 32'(bus1.carry), 32'(m_car[0]));
        chk("cnt_div4",   32'(bus4.cnt),   32'(int_to_bcd(m_cnt[1])));
        chk("carry_div4", 32'(bus4.carry), 32'(m_car[1]));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_div[0] = 1;
        m_div[1] = 4;
        rst = 1'b0; en = 1'b1; clr = 1'b0; load = 1'b0;
        load_val = 8'h00; limit = 8'h59;
        model_reset();

        // Reset held with en high: outputs stay cleared across edges.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cnt1",   32'(bus1.cnt),   32'h00);
        chk("rst_carry1", 32'(bus1.carry), 32'h0);
        chk("rst_cnt4",   32'(bus4.cnt),   32'h00);

        // Count 00..59 and wrap.
        rst = 1'b1;
        run(60);
`ifdef BCD_UP_SAT_EN
        chk("sat_at_59", 32'(bus1.cnt),   32'h59);
        chk("sat_carry", 32'(bus1.carry), 32'h1);
`else
        chk("wrap_to_00", 32'(bus1.cnt),   32'h00);
        chk("wrap_carry", 32'(bus1.carry), 32'h1);
`endif

        // Prescaler phase retained while en is low.
        clr = 1'b1; run(1); clr = 1'b0;
        limit = 8'h99;
        run(6);
        en = 1'b0; run(3);
        en = 1'b1; run(10);

        // Load above the limit, then an illegal-nibble load.
        limit = 8'h20;
        load = 1'b1; load_val = 8'h95; run(1); load = 1'b0;
        chk("load_95", 32'(bus1.cnt), 32'h95);
        run(6);
        load = 1'b1; load_val = 8'hA7; run(1); load = 1'b0;
        chk("load_sanitize", 32'(bus1.cnt), 32'h07);

        // Priority: clr over load over advance.
        clr = 1'b1; load = 1'b1; load_val = 8'h33; run(1);
        chk("prio_clr", 32'(bus1.cnt), 32'h00);
        clr = 1'b0; load_val = 8'h42; run(1); load = 1'b0;
        chk("prio_load", 32'(bus1.cnt), 32'h42);
        limit = 8'h99;
        run(5);
        load = 1'b1; load_val = 8'h17; run(1); load = 1'b0;
        run(3);

        // Limit nibble clamp: 3F acts as 39.
        clr = 1'b1; run(1); clr = 1'b0;
        limit = 8'h3F;
        run(45);

        // Saturation / short-limit run.
        clr = 1'b1; run(1); clr = 1'b0;
        limit = 8'h05;
        run(25);
`ifdef BCD_UP_SAT_EN
        chk("sat_hold_cnt",   32'(bus1.cnt),   32'h05);
        chk("sat_hold_carry", 32'(bus1.carry), 32'h1);
`endif
        clr = 1'b1; run(1); clr = 1'b0;
        chk("clr_carry", 32'(bus1.carry), 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            en       = ($urandom % 8) != 0;
            clr      = ($urandom % 60) == 0;
            load     = ($urandom % 30) == 0;
            load_val = 8'($urandom);
            if (($urandom % 150) == 0) limit = 8'($urandom);
            cycle();
        end

        // Asynchronous reset mid-count.
        en = 1'b1; clr = 1'b0; load = 1'b0; limit = 8'h99;
        load = 1'b1; load_val = 8'h10; run(1); load = 1'b0;
        run(7);
        rst = 1'b0;
        #2;
        model_reset();
        chk("async_rst_cnt1",   32'(bus1.cnt),   32'h00);
        chk("async_rst_cnt4",   32'(bus4.cnt),   32'h00);
        chk("async_rst_carry1", 32'(bus1.carry), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        run(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bcd_up_counter.md
# bcd_up_counter

Multi-digit synchronous BCD up-counter with prescaler, load, synchronous clear and a programmable terminal value. It is the count-up counterpart of the BCD down-counter in the lab04 timer path. It drives the seven-segment display chain and raises a carry toward the next counter stage. All digits advance together as one BCD value; each digit cell ripples its carry into the next, inside one clock.

## Interface
- DIGITS, default 2: number of BCD digits; value width is 4*DIGITS.
- DIV, default 1: prescale ratio; count advances once every DIV enabled clocks (DIV >= 1).
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset; one clock domain only.
- en  in  1  count enable; gates both the prescaler and the counter.
- clr  in  1  synchronous clear.
- load  in  1  synchronous load strobe.
- load_val  in  4*DIGITS  BCD value to load; digit 0 = bits [3:0].
- limit  in  4*DIGITS  terminal BCD value.
- cnt  out  4*DIGITS  current BCD count, registered.
- carry  out  1  terminal indication, registered; form depends on configuration.

## Operation
- Reset (rst=0, asynchronous):
  - cnt = 0, carry = 0, prescaler = 0.
  - Holds while rst=0; the first update is on the first rising edge after rst returns high.
- Per-edge priority: clr > load > advance > hold.
  - clr=1: cnt=0, prescaler=0, carry=0.
  - load=1: cnt=load_val with any nibble >9 replaced by 0; prescaler=0, carry=0.
  - advance: en=1 and prescaler==DIV-1. The prescaler then returns to 0.
  - en=1 without advance: prescaler+1, cnt holds.
  - en=0: prescaler and cnt hold; carry goes to 0 (wrap build).
- Limit handling:
  - Any limit nibble >9 is treated as 9.
  - limit is sampled every cycle; a mid-count change takes effect at the next advance.
- Advance, wrap build:
  - cnt==limit: cnt=0, carry=1 for exactly one cycle.
  - cnt!=limit: BCD increment. Digit 9 becomes 0 and carries into the next digit.
  - cnt above limit (reachable via load or a limit change): cnt keeps incrementing up to all-nines, then wraps to 0 and pulses carry.
- Non-advance cycles with clr=0 and load=0: carry=0 in the wrap build.

## Timing
- cnt and carry change only on rising clk edges, except for the asynchronous reset.
- Latency from an en/clr/load sample to cnt: 1 cycle.
- carry=1 appears in the same cycle cnt first reads 0 after a wrap.
- With DIV=1 and en held high, cnt changes every cycle; with DIV=N, every N cycles.
- clr or load asserted in the same cycle as an advance: the advance is discarded.
- Back-to-back load cycles: the last loaded value wins.

## Configuration
- Macro BCD_UP_SAT_EN.
- Defined (saturate build):
  - On an advance with cnt==limit, cnt holds at limit.
  - carry is a level, set high on that advance and held until clr, load or reset.
  - Further advances have no effect.
  - cnt above limit still counts up to all-nines, then holds there with carry=1.
- Not defined: wrap build, as in Operation.

## Structure
- Package bcd_pkg:
  - DIGIT_W=4, BCD_MAX=4'd9.
  - Function bcd_sanitize(nibble): returns 0 for nibble >9.
  - Function bcd_clamp(nibble): returns 9 for nibble >9.
- Sub-module bcd_digit, instantiated DIGITS times:
  - Inputs: digit value, inc_in.
  - Outputs: next digit, inc_out (set when digit==9 and inc_in).
- Top level owns:
  - prescaler register, width $clog2(DIV) with a minimum of 1;
  - terminal comparison;
  - priority mux;
  - carry register.

## Test plan
- Reset and wrap (DIVIDE=1, DIGITS=2, limit=8'h59): hold rst=0 with en=1 → cnt=8'h00, carry=0. Release rst and run 60 cycles → cnt passes 09→10 and 49→50, reaches 59, then 00 with carry high for exactly that one cycle.
- Prescaler (DIV=4, en=1, limit=8'h99): cnt increments once per 4 cycles. Drop en for 3 cycles mid-period → the prescaler phase is retained and the next increment is delayed by exactly 3 cycles.
- Load above limit (limit=8'h20): load 8'h95 → sequence 96, 97, 98, 99, then 00 with carry pulse. Load 8'hA7 → cnt=8'h07.
- Priority: clr=1, load=1 and an advance in the same cycle → cnt=00. Then load=1 with en=1 on the prescale boundary → cnt=load_val, no increment.
- Limit nibble clamp: limit=8'h3F → wrap occurs at 8'h39.
- Saturate (BCD_UP_SAT_EN defined, limit=8'h05): count to 05 → carry rises and stays high, cnt stays 05 for 20 more enabled cycles. Pulse clr → cnt=00, carry=0. Assert rst mid-count → cnt=00 immediately, without waiting for a clock edge.
